// File: rtl/z80_ed16_extaddr_seq.sv
// Sequencer for ED-prefixed LD dd,(nn) / LD (nn),dd: fetches nn, then moves a register pair
// to/from memory over the shared byte-wide port, with an optional per-access ack timeout.
module z80_ed16_extaddr_seq #(
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [7:0]  opcode_i,
  input  logic [15:0] pc_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] pc_next_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [3:0]  reg_rnum_o,
  input  logic [15:0] reg_rdata_i,
  output logic        reg_wr_o,
  output logic [3:0]  reg_wnum_o,
  output logic [15:0] reg_wdata_o
);

  localparam int unsigned CNT_W   = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);
  localparam int unsigned TO_LAST = (WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1;
  localparam bit          TO_EN   = (WAIT_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_LO, S_FETCH_HI, S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI, S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        pc_q, pc_d;
  logic [15:0]        nn_q, nn_d;
  logic [15:0]        data_q, data_d;
  logic               load_q, load_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [15:0]        pc_next_q, pc_next_d;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]         reg_rnum_q, reg_rnum_d, reg_wnum_q, reg_wnum_d;
  logic               reg_wr_q, reg_wr_d;
  logic [15:0]        reg_wdata_q, reg_wdata_d;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      nn_q        <= '0;
      data_q      <= '0;
      load_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pc_next_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      reg_rnum_q  <= '0;
      reg_wnum_q  <= '0;
      reg_wr_q    <= 1'b0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      nn_q        <= nn_d;
      data_q      <= data_d;
      load_q      <= load_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pc_next_q   <= pc_next_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      reg_rnum_q  <= reg_rnum_d;
      reg_wnum_q  <= reg_wnum_d;
      reg_wr_q    <= reg_wr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  // Next-state and registered-output computation; each access advances on mem_ack.
  always_comb begin
    logic acked;
    logic mem_st;
    state_d     = state_q;
    pc_d        = pc_q;
    nn_d        = nn_q;
    data_d      = data_q;
    load_d      = load_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    pc_next_d   = pc_next_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    reg_rnum_d  = reg_rnum_q;
    reg_wnum_d  = reg_wnum_q;
    reg_wr_d    = 1'b0;
    reg_wdata_d = reg_wdata_q;
    acked       = mem_req_q & mem_ack_i;
    mem_st      = (state_q != S_IDLE) && (state_q != S_FINISH);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (opcode_i[7:6] == 2'b01 && opcode_i[2:0] == 3'b011) begin
            state_d    = S_FETCH_LO;
            pc_d       = pc_i;
            load_d     = opcode_i[3];
            reg_rnum_d = {2'b10, opcode_i[5:4]};
            reg_wnum_d = {2'b10, opcode_i[5:4]};
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_i + 16'd2;
            cnt_d      = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH_LO: if (acked) begin
        nn_d[7:0]  = mem_rdata_i;
        state_d    = S_FETCH_HI;
        mem_addr_d = pc_q + 16'd3;
        cnt_d      = '0;
      end
      S_FETCH_HI: if (acked) begin
        nn_d[15:8] = mem_rdata_i;
        mem_addr_d = {mem_rdata_i, nn_q[7:0]};
        cnt_d      = '0;
        if (load_q) begin
          state_d = S_RD_LO;
        end else begin
          // Store snapshots the pair here so the two writes are coherent.
          data_d      = reg_rdata_i;
          state_d     = S_WR_LO;
          mem_we_d    = 1'b1;
          mem_wdata_d = reg_rdata_i[7:0];
        end
      end
      S_RD_LO: if (acked) begin
        data_d[7:0] = mem_rdata_i;
        state_d     = S_RD_HI;
        mem_addr_d  = nn_q + 16'd1;
        cnt_d       = '0;
      end
      S_RD_HI: if (acked) begin
        state_d     = S_FINISH;
        mem_req_d   = 1'b0;
        done_d      = 1'b1;
        pc_next_d   = pc_q + 16'd4;
        reg_wr_d    = 1'b1;
        reg_wdata_d = {mem_rdata_i, data_q[7:0]};
      end
      S_WR_LO: if (acked) begin
        state_d     = S_WR_HI;
        mem_addr_d  = nn_q + 16'd1;
        mem_wdata_d = data_q[15:8];
        cnt_d       = '0;
      end
      S_WR_HI: if (acked) begin
        state_d   = S_FINISH;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        done_d    = 1'b1;
        pc_next_d = pc_q + 16'd4;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Ack timeout abandons the instruction without retiring it.
    if (TO_EN && mem_st && !acked) begin
      if (cnt_q == CNT_W'(TO_LAST)) begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        err_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign pc_next_o   = pc_next_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign reg_rnum_o  = reg_rnum_q;
  assign reg_wr_o    = reg_wr_q;
  assign reg_wnum_o  = reg_wnum_q;
  assign reg_wdata_o = reg_wdata_q;

endmodule

// File: tb/tb_z80_ed16_extaddr_seq.sv
// Directed bench for z80_ed16_extaddr_seq: byte memory with programmable ack latency,
// register-pair model, and per-instruction monitors checked against hand-computed values.
module tb_z80_ed16_extaddr_seq;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [7:0]  opcode;
  logic [15:0] pc;
  logic        busy, done, err, mem_req, mem_we, mem_ack, reg_wr;
  logic [15:0] pc_next, mem_addr, reg_rdata, reg_wdata;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [3:0]  reg_rnum, reg_wnum;

  bit   [7:0]  mem [65536];
  logic [15:0] regs [4];

  int unsigned n_chk = 0, n_err = 0;

  // Monitor state
  int          cyc, lat, ack_budget, wcnt;
  int          n_done, n_errp, n_wr, n_busy, n_req, n_unstable;
  int          done_cyc, err_cyc;
  logic [15:0] pc_next_at_done, wdata_at_wr;
  logic [3:0]  wnum_at_wr;
  logic [24:0] prev_acc;
  logic        prev_wait;
  logic [24:0] log_acc [$];
  int          log_cyc [$];

  z80_ed16_extaddr_seq #(.WAIT_TIMEOUT(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .opcode_i(opcode), .pc_i(pc),
    .busy_o(busy), .done_o(done), .err_o(err), .pc_next_o(pc_next),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .reg_rnum_o(reg_rnum), .reg_rdata_i(reg_rdata),
    .reg_wr_o(reg_wr), .reg_wnum_o(reg_wnum), .reg_wdata_o(reg_wdata)
  );

  always #5 clk = ~clk;

  assign reg_rdata = regs[reg_rnum[1:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory responder and monitors, evaluated just after each active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (mem_req) begin
      if (prev_wait && prev_acc[24:8] !== {mem_we, mem_addr}) n_unstable++;
      prev_acc = {mem_we, mem_addr, mem_wdata};
      n_req++;
      if (ack_budget != 0 && wcnt >= lat - 1) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        log_acc.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem[mem_addr]});
        log_cyc.push_back(cyc);
        wcnt      = 0;
        prev_wait = 1'b0;
        if (ack_budget > 0) ack_budget--;
      end else begin
        mem_ack   = 1'b0;
        wcnt++;
        prev_wait = 1'b1;
      end
    end else begin
      mem_ack   = 1'b0;
      wcnt      = 0;
      prev_wait = 1'b0;
    end
    if (busy) n_busy++;
    if (done) begin n_done++; done_cyc = cyc; pc_next_at_done = pc_next; end
    if (err)  begin n_errp++; err_cyc = cyc; end
    if (reg_wr) begin n_wr++; wnum_at_wr = reg_wnum; wdata_at_wr = reg_wdata; end
  end

  task automatic clear_mon();
    cyc = 0; wcnt = 0; prev_wait = 1'b0;
    n_done = 0; n_errp = 0; n_wr = 0; n_busy = 0; n_req = 0; n_unstable = 0;
    done_cyc = -1; err_cyc = -1;
    log_acc.delete(); log_cyc.delete();
  endtask

  // Pulse start before edge 0 and wait (bounded) for retirement or error.
  task automatic run(input logic [7:0] op, input logic [15:0] p, input int wait_lat, input int budget);
    @(negedge clk);
    clear_mon();
    lat = wait_lat; ack_budget = budget;
    start = 1'b1; opcode = op; pc = p;
    @(negedge clk);
    start = 1'b0; opcode = 8'h00;
    for (int i = 0; i < 100; i++) begin
      if ((n_done > 0 || n_errp > 0) && !busy) break;
      @(negedge clk);
    end
    check("retire_bound", 32'(n_done + n_errp), 32'd1);
  endtask

  task automatic check_log(input string tag, input logic [24:0] e [4], input int c [4]);
    check({tag, "_nacc"}, 32'(log_acc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_acc.size()) begin
        check($sformatf("%s_acc%0d", tag, i), 32'(log_acc[i]), 32'(e[i]));
        check($sformatf("%s_cyc%0d", tag, i), 32'(log_cyc[i]), 32'(c[i]));
      end
    end
  endtask

  initial begin
    logic [24:0] e [4];
    int          c [4];
    reset_n = 1'b0; start = 1'b0; opcode = 8'h00; pc = 16'h0000;
    mem_ack = 1'b0; mem_rdata = 8'h00; lat = 1; ack_budget = -1;
    clear_mon();
    regs[0] = 16'h1111; regs[1] = 16'h2222; regs[2] = 16'h3333; regs[3] = 16'hBEEF;
    mem[16'h0102] = 8'h34; mem[16'h0103] = 8'h12; mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
    mem[16'h0202] = 8'hFF; mem[16'h0203] = 8'hFF;
    mem[16'h0402] = 8'h10; mem[16'h0403] = 8'h20; mem[16'h2010] = 8'h5A; mem[16'h2011] = 8'hA5;
    mem[16'h3000] = 8'h11; mem[16'h3001] = 8'h22;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_mem", 32'({mem_req, mem_we, mem_wdata}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_reg", 32'({reg_wr, reg_rnum, reg_wnum}), 32'd0);
    check("rst_data", 32'({reg_wdata, pc_next}), 32'd0);
    reset_n = 1'b1;

    // Load BC, zero wait
    run(8'h4B, 16'h0100, 1, -1);
    e = '{25'h0_0102_34, 25'h0_0103_12, 25'h0_1234_CD, 25'h0_1235_AB};
    c = '{1, 2, 3, 4};
    check_log("ldbc", e, c);
    check("ldbc_done_cyc", 32'(done_cyc), 32'd5);
    check("ldbc_nwr", 32'(n_wr), 32'd1);
    check("ldbc_wnum", 32'(wnum_at_wr), 32'h8);
    check("ldbc_wdata", 32'(wdata_at_wr), 32'hABCD);
    check("ldbc_pcnext", 32'(pc_next_at_done), 32'h0104);
    check("ldbc_busy", 32'(n_busy), 32'd5);
    check("ldbc_err", 32'(n_errp), 32'd0);

    // Store SP with nn wrap
    run(8'h73, 16'h0200, 1, -1);
    e = '{25'h0_0202_FF, 25'h0_0203_FF, 25'h1_FFFF_EF, 25'h1_0000_BE};
    check_log("stsp", e, c);
    check("stsp_mem", 32'({mem[16'hFFFF], mem[16'h0000]}), 32'hEFBE);
    check("stsp_nwr", 32'(n_wr), 32'd0);
    check("stsp_done_cyc", 32'(done_cyc), 32'd5);
    check("stsp_pcnext", 32'(pc_next_at_done), 32'h0204);

    // Load HL with pc wrap
    mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h30;
    run(8'h6B, 16'hFFFE, 1, -1);
    e = '{25'h0_0000_00, 25'h0_0001_30, 25'h0_3000_11, 25'h0_3001_22};
    check_log("ldhl", e, c);
    check("ldhl_wnum", 32'(wnum_at_wr), 32'hA);
    check("ldhl_wdata", 32'(wdata_at_wr), 32'h2211);
    check("ldhl_pcnext", 32'(pc_next_at_done), 32'h0002);

    // Load DE with 3-cycle ack latency
    run(8'h5B, 16'h0400, 3, -1);
    e = '{25'h0_0402_10, 25'h0_0403_20, 25'h0_2010_5A, 25'h0_2011_A5};
    c = '{3, 6, 9, 12};
    check_log("ldde", e, c);
    check("ldde_done_cyc", 32'(done_cyc), 32'd13);
    check("ldde_stable", 32'(n_unstable), 32'd0);
    check("ldde_busy", 32'(n_busy), 32'd13);
    check("ldde_wdata", 32'({wnum_at_wr, wdata_at_wr}), 32'h9A55A);

    // Illegal opcode
    run(8'h4A, 16'h0100, 1, -1);
    check("ill_err_cyc", 32'(err_cyc), 32'd1);
    check("ill_busy", 32'(n_busy), 32'd0);
    check("ill_req", 32'(n_req), 32'd0);
    check("ill_done", 32'(n_done), 32'd0);

    // Reset during RD_HI
    @(negedge clk);
    clear_mon(); lat = 1; ack_budget = -1;
    start = 1'b1; opcode = 8'h4B; pc = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rmid_in_rdhi", 32'({mem_req, mem_addr}), 32'h11235);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rmid_req", 32'(mem_req), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("rmid_wr_done", 32'({n_wr[7:0], n_done[7:0]}), 32'd0);

    // Ack withheld in FETCH_HI, then a fresh instruction
    run(8'h4B, 16'h0100, 1, 1);
    check("to_err_cyc", 32'(err_cyc), 32'd6);
    check("to_done", 32'(n_done), 32'd0);
    check("to_nwr", 32'(n_wr), 32'd0);
    check("to_idle", 32'({busy, mem_req}), 32'd0);
    run(8'h4B, 16'h0100, 1, -1);
    check("to_restart", 32'({done_cyc[7:0], wdata_at_wr}), 32'h05ABCD);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
